// File: rtl/em_pipe_reg_if.sv
// Execute-to-memory pipeline register bundle.
// The "master" side is the E stage, which drives the E-side fields and reads
// the registered M-side fields. The "slave" side is the pipeline register.
interface em_pipe_reg_if;
  logic        en;
  logic        req;
  logic [31:0] pc_E;
  logic [31:0] instr_E;
  logic [31:0] alu_C_E;
  logic [31:0] rt_data_E;
  logic [4:0]  a3_E;
  logic [1:0]  tnew_E;
  logic        bd_E;
  logic [4:0]  exccode_E;
  logic        is_load_E;
  logic        is_store_E;
  logic        EXC_AriOv;
  logic        EXC_DMOv;

  logic [31:0] pc_M;
  logic [31:0] instr_M;
  logic [31:0] alu_C_M;
  logic [31:0] rt_data_M;
  logic [4:0]  a3_M;
  logic [1:0]  tnew_M;
  logic        bd_M;
  logic [4:0]  exccode_M;

  modport master (
    output en, req, pc_E, instr_E, alu_C_E, rt_data_E, a3_E, tnew_E, bd_E,
           exccode_E, is_load_E, is_store_E, EXC_AriOv, EXC_DMOv,
    input  pc_M, instr_M, alu_C_M, rt_data_M, a3_M, tnew_M, bd_M, exccode_M
  );

  modport slave (
    input  en, req, pc_E, instr_E, alu_C_E, rt_data_E, a3_E, tnew_E, bd_E,
           exccode_E, is_load_E, is_store_E, EXC_AriOv, EXC_DMOv,
    output pc_M, instr_M, alu_C_M, rt_data_M, a3_M, tnew_M, bd_M, exccode_M
  );
endinterface

// File: rtl/em_pipe_reg.sv
// Execute-to-memory pipeline register of the five-stage MIPS core.
// Captures E-stage results for the M stage one cycle later, decrements the
// hazard tnew counter, and merges ALU overflow flags into a MIPS exccode.
// Optional feature macro: EM_EXC_EN. When undefined, exccode_M and bd_M are
// tied to zero and the exception-related inputs are ignored.
module em_pipe_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] FLUSH_PC = 32'h0000_4180
) (
  input logic        clk,
  input logic        reset,
  em_pipe_reg_if.slave bus
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] aluC_q, aluC_d;
  logic [31:0] rtData_q, rtData_d;
  logic [4:0]  a3_q, a3_d;
  logic [1:0]  tnew_q, tnew_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;

  logic [1:0]  tnewDec;
  logic [4:0]  excMerged;
  logic        bdIn;

  // tnew counts down toward zero and must never wrap back to 3
  always_comb begin
    tnewDec = (bus.tnew_E == 2'd0) ? 2'd0 : bus.tnew_E - 2'd1;
  end

`ifdef EM_EXC_EN
  // Earlier-stage exceptions win, then arithmetic overflow, then address faults
  always_comb begin
    excMerged = EXC_NONE;
    bdIn      = bus.bd_E;
    if (bus.exccode_E != EXC_NONE)
      excMerged = bus.exccode_E;
    else if (bus.EXC_AriOv)
      excMerged = EXC_OV;
    else if (bus.EXC_DMOv && bus.is_load_E)
      excMerged = EXC_ADEL;
    else if (bus.EXC_DMOv && bus.is_store_E)
      excMerged = EXC_ADES;
  end
`else
  logic unusedExcInputs;

  // Exception support is compiled out, so these inputs have no effect
  always_comb begin
    excMerged       = EXC_NONE;
    bdIn            = 1'b0;
    unusedExcInputs = ^{bus.exccode_E, bus.EXC_AriOv, bus.EXC_DMOv,
                        bus.is_load_E, bus.is_store_E, bus.bd_E,
                        EXC_ADEL, EXC_ADES, EXC_OV};
  end
`endif

  // Flush beats hold beats load; reset is handled in the register itself
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    aluC_d    = aluC_q;
    rtData_d  = rtData_q;
    a3_d      = a3_q;
    tnew_d    = tnew_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    if (bus.req) begin
      pc_d      = FLUSH_PC;
      instr_d   = 32'd0;
      aluC_d    = 32'd0;
      rtData_d  = 32'd0;
      a3_d      = 5'd0;
      tnew_d    = 2'd0;
      bd_d      = 1'b0;
      exccode_d = EXC_NONE;
    end else if (bus.en) begin
      pc_d      = bus.pc_E;
      instr_d   = bus.instr_E;
      aluC_d    = bus.alu_C_E;
      rtData_d  = bus.rt_data_E;
      a3_d      = bus.a3_E;
      tnew_d    = tnewDec;
      bd_d      = bdIn;
      exccode_d = excMerged;
    end
  end

  // Output registers with synchronous reset to the boot PC
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      aluC_q    <= 32'd0;
      rtData_q  <= 32'd0;
      a3_q      <= 5'd0;
      tnew_q    <= 2'd0;
      bd_q      <= 1'b0;
      exccode_q <= EXC_NONE;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      aluC_q    <= aluC_d;
      rtData_q  <= rtData_d;
      a3_q      <= a3_d;
      tnew_q    <= tnew_d;
      bd_q      <= bd_d;
      exccode_q <= exccode_d;
    end
  end

  assign bus.pc_M      = pc_q;
  assign bus.instr_M   = instr_q;
  assign bus.alu_C_M   = aluC_q;
  assign bus.rt_data_M = rtData_q;
  assign bus.a3_M      = a3_q;
  assign bus.tnew_M    = tnew_q;
  assign bus.bd_M      = bd_q;
  assign bus.exccode_M = exccode_q;

endmodule
